ula_bist: RTL and testbench

ULA_BIST -- requirements
Module: ula_bist

---
 rtl/ula_pkg.sv | 57 +++++
 rtl/ula_bist_if.sv | 26 ++
 rtl/ula_bist.sv | 154 +++++++++++++++
 tb/tb_ula_bist.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// ula_pkg: shared ULA opcodes, flag/vector types, BIST FSM states and the
// constant 8-entry self-test vector table.
package ula_pkg;

  localparam int TBL_BITS = 3;
  localparam int NUM_VEC  = 8;

  typedef logic [4:0] op_t;

  localparam op_t OP_ADD    = 5'b00000;
  localparam op_t OP_ADDINC = 5'b00001;
  localparam op_t OP_INC    = 5'b00011;
  localparam op_t OP_SUBDEC = 5'b00100;

  // ULA status flags in {O,C,S,Z} order
  typedef struct packed {
    logic o;
    logic c;
    logic s;
    logic z;
  } flags_t;

  // One self-test vector: stimulus plus the response a healthy ULA gives
  typedef struct packed {
    op_t                 op;
    logic [TBL_BITS-1:0] a;
    logic [TBL_BITS-1:0] b;
    logic [TBL_BITS-1:0] exp_resu;
    flags_t              exp_flags;
  } vec_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_APPLY = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Constant vector table, indexed 0..7
  function automatic vec_t get_vec(input logic [2:0] idx);
    vec_t v;
    case (idx)
      3'd0:    v = '{OP_ADD,    3'b001, 3'b111, 3'b000, flags_t'(4'b0101)};
      3'd1:    v = '{OP_ADD,    3'b010, 3'b011, 3'b101, flags_t'(4'b1010)};
      3'd2:    v = '{OP_ADD,    3'b100, 3'b111, 3'b011, flags_t'(4'b1100)};
      3'd3:    v = '{OP_ADD,    3'b001, 3'b010, 3'b011, flags_t'(4'b0000)};
      3'd4:    v = '{OP_ADDINC, 3'b000, 3'b111, 3'b000, flags_t'(4'b0101)};
      3'd5:    v = '{OP_ADDINC, 3'b001, 3'b010, 3'b100, flags_t'(4'b1010)};
      3'd6:    v = '{OP_INC,    3'b011, 3'b000, 3'b100, flags_t'(4'b1010)};
      3'd7:    v = '{OP_INC,    3'b111, 3'b000, 3'b000, flags_t'(4'b0101)};
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/ula_bist_if.sv
// ula_bist_if: bus between the BIST sequencer (master) and the ULA under
// test (slave): operands/opcode out, result and flags back.
interface ula_bist_if #(
  parameter int BITS = 3
);

  logic [BITS-1:0] ula_a;
  logic [BITS-1:0] ula_b;
  logic [4:0]      ula_op;
  logic [BITS-1:0] ula_resu;
  logic            ula_o;
  logic            ula_c;
  logic            ula_s;
  logic            ula_z;

  modport master (
    output ula_a, ula_b, ula_op,
    input  ula_resu, ula_o, ula_c, ula_s, ula_z
  );

  modport slave (
    input  ula_a, ula_b, ula_op,
    output ula_resu, ula_o, ula_c, ula_s, ula_z
  );

endinterface

// File: rtl/ula_bist.sv
// ula_bist: built-in self test for the ULA. Applies the 8 table vectors,
// waits SETTLE cycles for each, compares result and flags, and reports the
// error count, the first failing vector and an overall pass flag.
module ula_bist
  import ula_pkg::*;
#(
  parameter int BITS   = 3,
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  ula_bist_if.master ula,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_err
);

  localparam logic [2:0] LAST_IDX  = 3'(NUM_VEC - 1);
  localparam logic [2:0] WAIT_LAST = (SETTLE > 0) ? 3'(SETTLE - 1) : 3'd0;
  localparam bit         NO_WAIT   = (SETTLE == 0);

  state_t     state_r;
  logic [2:0] idx_r;
  logic [2:0] wcnt_r;

  vec_t       cur_s;
  vec_t       nxt_s;
  vec_t       first_s;
  flags_t     flags_s;
  logic       mism_s;
  logic [3:0] err_inc_s;

  // Fetch current/next vectors and judge the ULA response against the current one
  always_comb begin
    cur_s   = get_vec(idx_r);
    nxt_s   = get_vec(idx_r + 3'd1);
    first_s = get_vec(3'd0);
    flags_s = {ula.ula_o, ula.ula_c, ula.ula_s, ula.ula_z};
    if ((ula.ula_resu != BITS'(cur_s.exp_resu)) || (flags_s != cur_s.exp_flags)) begin
      mism_s = 1'b1;
    end else begin
      mism_s = 1'b0;
    end
    if (err_count == 4'd15) begin
      err_inc_s = 4'd15;
    end else begin
      err_inc_s = err_count + 4'd1;
    end
  end

  // Sequencer FSM: walks the vector table, drives the ULA and keeps the run result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      idx_r      <= 3'd0;
      wcnt_r     <= 3'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 4'd0;
      first_err  <= 3'd0;
      ula.ula_a  <= '0;
      ula.ula_b  <= '0;
      ula.ula_op <= 5'd0;
    end else if (abort && (state_r != ST_IDLE)) begin
      // cancelled run: back to idle, result counters frozen, no completion pulse
      state_r    <= ST_IDLE;
      idx_r      <= 3'd0;
      wcnt_r     <= 3'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      ula.ula_a  <= '0;
      ula.ula_b  <= '0;
      ula.ula_op <= 5'd0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r    <= ST_APPLY;
            idx_r      <= 3'd0;
            wcnt_r     <= 3'd0;
            busy       <= 1'b1;
            pass       <= 1'b0;
            err_count  <= 4'd0;
            first_err  <= 3'd0;
            ula.ula_a  <= BITS'(first_s.a);
            ula.ula_b  <= BITS'(first_s.b);
            ula.ula_op <= first_s.op;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_APPLY: begin
          wcnt_r <= 3'd0;
          if (NO_WAIT) begin
            state_r <= ST_CHECK;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wcnt_r == WAIT_LAST) begin
            state_r <= ST_CHECK;
          end else begin
            wcnt_r <= wcnt_r + 3'd1;
          end
        end
        ST_CHECK: begin
          if (mism_s) begin
            err_count <= err_inc_s;
            // a zero count means no earlier failure in this run
            if (err_count == 4'd0) begin
              first_err <= idx_r;
            end
          end
          if (idx_r == LAST_IDX) begin
            state_r    <= ST_DONE;
            idx_r      <= 3'd0;
            busy       <= 1'b0;
            done       <= 1'b1;
            pass       <= (err_count == 4'd0) && !mism_s;
            ula.ula_a  <= '0;
            ula.ula_b  <= '0;
            ula.ula_op <= 5'd0;
          end else begin
            state_r    <= ST_APPLY;
            idx_r      <= idx_r + 3'd1;
            ula.ula_a  <= BITS'(nxt_s.a);
            ula.ula_b  <= BITS'(nxt_s.b);
            ula.ula_op <= nxt_s.op;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r    <= ST_IDLE;
          idx_r      <= 3'd0;
          busy       <= 1'b0;
          ula.ula_a  <= '0;
          ula.ula_b  <= '0;
          ula.ula_op <= 5'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_bist.sv
// tb_ula_bist: runs two BIST instances (SETTLE=0 and SETTLE=1) side by side
// against behavioural ULA models with injectable faults. Expected timing,
// error counts and pass flags come from a cycle-level view of the vector
// schedule and from the vector table values.
module tb_ula_bist;

  typedef struct packed {
    logic [4:0] op;
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] resu;
    logic [3:0] fl;   // {O,C,S,Z}
  } vec_rec_t;

  typedef struct {
    bit fc;
    bit fz;
    int bad;
    int ab;
    int gl;
    int e_err;
    int e_first;
    int e_pass;
  } row_t;

  logic clk;
  logic rst;
  logic start;
  logic abort;

  bit          fc;
  bit          fz;
  logic [55:0] fmask_flat;

  int nchk;
  int nerr;

  logic       busy_v [2];
  logic       done_v [2];
  logic       pass_v [2];
  logic [3:0] ec_v   [2];
  logic [2:0] fe_v   [2];
  logic [2:0] a_v    [2];
  logic [2:0] b_v    [2];
  logic [4:0] op_v   [2];
  logic [6:0] r0_s;
  logic [6:0] r1_s;

  row_t rows [9];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ula_bist_if #(.BITS(3)) if0 ();
  ula_bist_if #(.BITS(3)) if1 ();

  ula_bist #(.BITS(3), .SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ula(if0),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .err_count(ec_v[0]), .first_err(fe_v[0])
  );

  ula_bist #(.BITS(3), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ula(if1),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .err_count(ec_v[1]), .first_err(fe_v[1])
  );

  // vector table as written in the requirements
  function automatic vec_rec_t spec_vec(input int j);
    vec_rec_t v;
    case (j)
      0:       v = '{5'b00000, 3'b001, 3'b111, 3'b000, 4'b0101};
      1:       v = '{5'b00000, 3'b010, 3'b011, 3'b101, 4'b1010};
      2:       v = '{5'b00000, 3'b100, 3'b111, 3'b011, 4'b1100};
      3:       v = '{5'b00000, 3'b001, 3'b010, 3'b011, 4'b0000};
      4:       v = '{5'b00001, 3'b000, 3'b111, 3'b000, 4'b0101};
      5:       v = '{5'b00001, 3'b001, 3'b010, 3'b100, 4'b1010};
      6:       v = '{5'b00011, 3'b011, 3'b000, 3'b100, 4'b1010};
      7:       v = '{5'b00011, 3'b111, 3'b000, 3'b000, 4'b0101};
      default: v = '0;
    endcase
    return v;
  endfunction

  // healthy 3-bit ULA by plain integer arithmetic: returns {resu,O,C,S,Z}
  function automatic logic [6:0] ula_ref(input logic [4:0] op, input logic [2:0] a,
                                         input logic [2:0] b);
    int bi, ci, sum, sa, sb, ss;
    logic [2:0] r;
    logic o, c, s, z;
    case (op)
      5'b00000: begin bi = int'(b);     ci = 0; end
      5'b00001: begin bi = int'(b);     ci = 1; end
      5'b00011: begin bi = 0;           ci = 1; end
      5'b00100: begin bi = 7 - int'(b); ci = 0; end
      default:  begin bi = 0;           ci = 0; end
    endcase
    sum = int'(a) + bi + ci;
    r   = 3'(sum);
    c   = (sum > 7);
    sa  = a[2] ? int'(a) - 8 : int'(a);
    sb  = (bi > 3) ? bi - 8 : bi;
    ss  = sa + sb + ci;
    o   = (ss > 3) || (ss < -4);
    s   = r[2];
    z   = (r == 3'd0);
    return {r, o, c, s, z};
  endfunction

  // ULA with stuck-at-0 C/Z and per-vector XOR corruption
  function automatic logic [6:0] ula_faulty(input logic [4:0] op, input logic [2:0] a,
                                            input logic [2:0] b, input bit f_c, input bit f_z,
                                            input logic [55:0] fm);
    logic [6:0] r;
    vec_rec_t v;
    r = ula_ref(op, a, b);
    if (f_c) r[2] = 1'b0;
    if (f_z) r[0] = 1'b0;
    for (int j = 0; j < 8; j++) begin
      v = spec_vec(j);
      if (v.op == op && v.a == a && v.b == b) r = r ^ fm[j*7 +: 7];
    end
    return r;
  endfunction

  assign r0_s = ula_faulty(if0.ula_op, if0.ula_a, if0.ula_b, fc, fz, fmask_flat);
  assign r1_s = ula_faulty(if1.ula_op, if1.ula_a, if1.ula_b, fc, fz, fmask_flat);
  assign if0.ula_resu = r0_s[6:4];
  assign if0.ula_o    = r0_s[3];
  assign if0.ula_c    = r0_s[2];
  assign if0.ula_s    = r0_s[1];
  assign if0.ula_z    = r0_s[0];
  assign if1.ula_resu = r1_s[6:4];
  assign if1.ula_o    = r1_s[3];
  assign if1.ula_c    = r1_s[2];
  assign if1.ula_s    = r1_s[1];
  assign if1.ula_z    = r1_s[0];
  assign a_v[0]  = if0.ula_a;
  assign b_v[0]  = if0.ula_b;
  assign op_v[0] = if0.ula_op;
  assign a_v[1]  = if1.ula_a;
  assign b_v[1]  = if1.ula_b;
  assign op_v[1] = if1.ula_op;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // does vector j respond wrongly under the current fault setting
  function automatic bit is_faulty(input int j);
    vec_rec_t v;
    v = spec_vec(j);
    return (fmask_flat[j*7 +: 7] != 7'd0) || (fc && v.fl[2]) || (fz && v.fl[0]);
  endfunction

  // one run on both instances; ab = abort cycle (0 none), gl = cycle with a stray start
  task automatic do_run(input string nm, input int ab, input int gl);
    int per, tot, last, cnt, first, lim;
    int dcyc [2];
    int bad  [2];
    vec_rec_t v;
    dcyc[0] = 0; dcyc[1] = 0; bad[0] = 0; bad[1] = 0;
    @(negedge clk);
    start = 1'b1;
    abort = 1'b0;
    for (int n = 1; n <= 28; n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        per  = k + 2;
        tot  = 8 * per;
        last = (ab > 0) ? ab : tot;
        if (n <= last) begin
          v = spec_vec((n - 1) / per);
          if (busy_v[k] !== 1'b1 || pass_v[k] !== 1'b0 || op_v[k] !== v.op ||
              a_v[k] !== v.a || b_v[k] !== v.b) bad[k]++;
        end else begin
          if (busy_v[k] !== 1'b0 || op_v[k] !== 5'd0 || a_v[k] !== 3'd0 ||
              b_v[k] !== 3'd0) bad[k]++;
        end
        if (done_v[k] === 1'b1 && dcyc[k] == 0) dcyc[k] = n;
        if ((done_v[k] === 1'b1) != ((ab == 0) && (n == tot + 1))) bad[k]++;
      end
      start = (gl > 0 && n == gl);
      abort = (ab > 0 && n == ab);
    end
    for (int k = 0; k < 2; k++) begin
      per   = k + 2;
      tot   = 8 * per;
      lim   = (ab > 0) ? ab : 1000;
      cnt   = 0;
      first = -1;
      for (int j = 0; j < 8; j++) begin
        if (is_faulty(j) && (j + 1) * per < lim) begin
          cnt++;
          if (first < 0) first = j;
        end
      end
      if (cnt > 15) cnt = 15;
      if (first < 0) first = 0;
      chk($sformatf("%s s%0d drive_busy_done", nm, k), 32'(bad[k]), 32'd0);
      chk($sformatf("%s s%0d done_cycle", nm, k), 32'(dcyc[k]), 32'((ab > 0) ? 0 : tot + 1));
      chk($sformatf("%s s%0d err_count", nm, k), 32'(ec_v[k]), 32'(cnt));
      chk($sformatf("%s s%0d first_err", nm, k), 32'(fe_v[k]), 32'(first));
      chk($sformatf("%s s%0d pass", nm, k), 32'(pass_v[k]), 32'((ab == 0) && (cnt == 0)));
    end
  endtask

  initial begin
    int ab, gl;
    nchk = 0; nerr = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    fc = 1'b0; fz = 1'b0; fmask_flat = '0;

    //         fc    fz    bad ab  gl  err first pass   (err/first/pass for SETTLE=1)
    rows[0] = '{1'b0, 1'b0, -1, 0,  0,  0,  0,    1};
    rows[1] = '{1'b1, 1'b0, -1, 0,  0,  4,  0,    0};
    rows[2] = '{1'b0, 1'b1, -1, 0,  0,  3,  0,    0};
    rows[3] = '{1'b0, 1'b0, -1, 0,  10, 0,  0,    1};
    rows[4] = '{1'b0, 1'b0, 5,  0,  0,  1,  5,    0};
    rows[5] = '{1'b1, 1'b0, 3,  0,  0,  5,  0,    0};
    rows[6] = '{1'b1, 1'b0, -1, 11, 0,  2,  0,    0};
    rows[7] = '{1'b1, 1'b0, -1, 9,  0,  1,  0,    0};
    rows[8] = '{1'b0, 1'b0, 1,  6,  0,  0,  0,    0};

    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_state s%0d", k),
          32'({busy_v[k], done_v[k], pass_v[k], ec_v[k], fe_v[k], op_v[k], a_v[k], b_v[k]}),
          32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      fc = rows[i].fc;
      fz = rows[i].fz;
      fmask_flat = '0;
      if (rows[i].bad >= 0) fmask_flat[rows[i].bad*7 +: 7] = 7'b0000010;
      do_run($sformatf("row%0d", i), rows[i].ab, rows[i].gl);
      chk($sformatf("row%0d tbl_err", i), 32'(ec_v[1]), 32'(rows[i].e_err));
      chk($sformatf("row%0d tbl_first", i), 32'(fe_v[1]), 32'(rows[i].e_first));
      chk($sformatf("row%0d tbl_pass", i), 32'(pass_v[1]), 32'(rows[i].e_pass));
    end

    fc = 1'b0;
    fz = 1'b0;
    for (int r = 0; r < 12; r++) begin
      for (int j = 0; j < 8; j++) begin
        fmask_flat[j*7 +: 7] = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
      end
      ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 16)) : 0;
      gl = (ab == 0) ? int'($urandom_range(2, 15)) : 0;
      do_run($sformatf("rnd%0d", r), ab, gl);
    end

    // reset in the middle of vector 5 of the SETTLE=1 run
    fmask_flat = '0;
    fc = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("midrun s1 err_count", 32'(ec_v[1]), 32'd3);
    chk("midrun s1 busy", 32'(busy_v[1]), 32'd1);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("midrun_reset s%0d", k),
          32'({busy_v[k], done_v[k], pass_v[k], ec_v[k], fe_v[k], op_v[k], a_v[k], b_v[k]}),
          32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_reset idle s0", 32'(busy_v[0]), 32'd0);
    chk("post_reset idle s1", 32'(busy_v[1]), 32'd0);
    fc = 1'b0;
    do_run("post_reset", 0, 0);
    chk("post_reset s1 pass", 32'(pass_v[1]), 32'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
